// File: rtl/clk_rst_seq.sv
// Reset and clock-enable sequencer between the PLL and the core: waits for a
// stable lock, releases reset, divides clk into ce pulses and records why reset was re-entered.
module clk_rst_seq #(
  parameter int LOCK_CYCLES = 1024,
  parameter int RST_CYCLES  = 16,
  parameter int DIV         = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  input  logic       soft_rst_req,
  output logic       sys_rst,
  output logic       ce,
  output logic       running,
  output logic [1:0] cause,
  output logic [7:0] lock_lost_cnt
);

  localparam int MAXC = (LOCK_CYCLES > RST_CYCLES) ? LOCK_CYCLES : RST_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST    = DW'(DIV - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2,
    SOFT_HOLD = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'b00,
    CAUSE_LOCK = 2'b01,
    CAUSE_SOFT = 2'b10
  } cause_e;

  state_e          state_q, state_d;
  cause_e          cause_q, cause_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   div_q, div_d;
  logic [7:0]      lost_q, lost_d;
  logic            sync1_q, locked_s_q;
  logic            sys_rst_q, ce_q, running_q;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    lost_d  = lost_q;
    cnt_d   = cnt_q + CW'(1);

    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s_q) state_d = SETTLE;
      end
      SETTLE: begin
        if (!locked_s_q)                state_d = WAIT_LOCK;
        else if (cnt_q == SETTLE_LAST)  state_d = RUN;
      end
      RUN: begin
        cnt_d = '0;
        // Lock loss outranks a simultaneous software request.
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          cause_d = CAUSE_LOCK;
          lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        end else if (soft_rst_req) begin
          state_d = SOFT_HOLD;
          cause_d = CAUSE_SOFT;
        end
      end
      SOFT_HOLD: begin
        if (!locked_s_q) begin
          state_d = WAIT_LOCK;
          cause_d = CAUSE_LOCK;
          lost_d  = (lost_q == 8'hFF) ? lost_q : lost_q + 8'd1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // The divider only advances while staying in RUN, so each RUN entry restarts it.
    div_d = '0;
    if (state_q == RUN && state_d == RUN)
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from the values sampled at the edge.
  // NOTE: every flop here is reset, including the lock synchronizer, so the
  // sequence always restarts from a known WAIT_LOCK with no stale lock history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
      state_q    <= WAIT_LOCK;
      cause_q    <= CAUSE_POR;
      cnt_q      <= '0;
      div_q      <= '0;
      lost_q     <= 8'd0;
      sys_rst_q  <= 1'b1;
      ce_q       <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      sync1_q    <= locked;
      locked_s_q <= sync1_q;
      state_q    <= state_d;
      cause_q    <= cause_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      lost_q     <= lost_d;
      sys_rst_q  <= (state_d != RUN);
      running_q  <= (state_d == RUN);
      ce_q       <= (state_d == RUN) && (div_d == DIV_LAST);
    end
  end

  assign sys_rst       = sys_rst_q;
  assign ce            = ce_q;
  assign running       = running_q;
  assign cause         = cause_q;
  assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Self-checking bench for clk_rst_seq: a lock-history model checked every cycle
// plus directed scenarios with hand-computed edge counts and values.
module tb_clk_rst_seq;

  localparam int L = 8;
  localparam int R = 4;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic       sys_rst, ce, running;
  logic [1:0] cause;
  logic [7:0] lock_lost_cnt;

  int checks = 0;
  int errors = 0;

  clk_rst_seq #(.LOCK_CYCLES(L), .RST_CYCLES(R), .DIV(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .locked       (locked),
    .soft_rst_req (soft_rst_req),
    .sys_rst      (sys_rst),
    .ce           (ce),
    .running      (running),
    .cause        (cause),
    .lock_lost_cnt(lock_lost_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the core runs once the synchronized lock has been seen high for
  // L+1 consecutive edges and no software hold is pending.
  bit         p0, p1;
  int         up, hold_left, run_age, m_cnt;
  logic [1:0] m_cause;
  bit         m_run;

  task automatic model_reset();
    p0 = 0; p1 = 0; up = 0; hold_left = 0; run_age = 0;
    m_cnt = 0; m_cause = 2'b00; m_run = 0;
  endtask

  task automatic model_step();
    bit seen, engaged, was_run;
    seen    = p1;
    p1      = p0;
    p0      = locked;
    engaged = (up >= L + 1);
    was_run = engaged && (hold_left == 0);
    if (!seen) begin
      if (engaged) begin
        m_cause = 2'b01;
        if (m_cnt < 255) m_cnt++;
      end
      up = 0;
      hold_left = 0;
    end else begin
      if (up < L + 1) up++;
      if (hold_left > 0) hold_left--;
      else if (was_run && soft_rst_req) begin
        hold_left = R;
        m_cause = 2'b10;
      end
    end
    m_run   = (up >= L + 1) && (hold_left == 0);
    run_age = m_run ? (was_run ? run_age + 1 : 1) : 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1;
      check("cmp_sys_rst", sys_rst, !m_run);
      check("cmp_running", running, m_run);
      check("cmp_ce", ce, m_run && (run_age % D == 0));
      check("cmp_cause", cause, m_cause);
      check("cmp_lost_cnt", lock_lost_cnt, m_cnt);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout watchdog expired");
    $fatal(1);
  end

  // Counts edges until sys_rst equals want; n = -1 if the bound expires.
  task automatic edges_until(input logic want, input int max_e, output int n);
    n = -1;
    for (int k = 1; k <= max_e; k++) begin
      @(posedge clk); #1;
      if (sys_rst === want) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n, hi, bad;
    logic [5:0] pat;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_sys_rst", sys_rst, 1);
    check("rst_ce", ce, 0);
    check("rst_running", running, 0);
    check("rst_cause", cause, 0);
    check("rst_lost_cnt", lock_lost_cnt, 0);

    // Power-up with a 3-cycle lock glitch mid-settle
    @(negedge clk); rst = 1'b0; locked = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk); locked = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); locked = 1'b1;
    edges_until(1'b0, 30, n);
    check("glitch_release_edge", n, L + 3);
    check("glitch_lost_cnt", lock_lost_cnt, 0);
    check("glitch_cause", cause, 0);

    // ce pattern over RUN cycles 1..6
    pat = '0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      pat[c-1] = ce;
    end
    check("run_ce_pattern", pat, 6'b101010);

    // Lock loss in RUN, then relock
    @(negedge clk); locked = 1'b0;
    edges_until(1'b1, 10, n);
    check("loss_rise_edge", n, 3);
    check("loss_ce", ce, 0);
    check("loss_cause", cause, 2'b01);
    check("loss_lost_cnt", lock_lost_cnt, 1);
    @(negedge clk); locked = 1'b1;
    edges_until(1'b0, 30, n);
    check("relock_release_edge", n, L + 3);

    // Software reset
    @(negedge clk); soft_rst_req = 1'b1;
    @(posedge clk); #1;
    check("soft_rise", sys_rst, 1);
    @(negedge clk); soft_rst_req = 1'b0;
    hi = 1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (!sys_rst) break;
      hi++;
    end
    check("soft_hold_len", hi, R);
    check("soft_cause", cause, 2'b10);
    check("soft_run1_ce", ce, 0);
    @(posedge clk); #1;
    check("soft_first_ce", ce, 1);

    // Lock loss and software request seen on the same edge
    @(negedge clk); locked = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); soft_rst_req = 1'b1;
    @(posedge clk); #1;
    check("simul_sys_rst", sys_rst, 1);
    check("simul_cause", cause, 2'b01);
    check("simul_lost_cnt", lock_lost_cnt, 2);
    @(negedge clk); soft_rst_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("simul_no_hold_cnt", lock_lost_cnt, 2);
    check("simul_still_rst", sys_rst, 1);

    // 260 lock-loss events saturate the counter
    bad = 0;
    for (int i = 0; i < 260; i++) begin
      @(negedge clk); locked = 1'b1;
      edges_until(1'b0, 20, n);
      if (n < 0) bad++;
      @(negedge clk); locked = 1'b0;
      edges_until(1'b1, 10, n);
      if (n < 0) bad++;
    end
    check("sat_bounds", bad, 0);
    check("sat_lost_cnt", lock_lost_cnt, 255);

    // Async reset while in SOFT_HOLD
    @(negedge clk); locked = 1'b1;
    edges_until(1'b0, 20, n);
    @(negedge clk); soft_rst_req = 1'b1;
    @(posedge clk); #1;
    check("sh_cause", cause, 2'b10);
    #1; rst = 1'b1; soft_rst_req = 1'b0;
    #1;
    check("sh_async_sys_rst", sys_rst, 1);
    check("sh_async_running", running, 0);
    check("sh_async_cause", cause, 0);
    check("sh_async_lost_cnt", lock_lost_cnt, 0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    edges_until(1'b0, 30, n);
    check("sh_restart_edge", n, L + 3);

    // Async reset in RUN during a ce pulse
    @(posedge clk); #1;
    check("run_ce_before", ce, 1);
    #1; rst = 1'b1;
    #1;
    check("run_async_ce", ce, 0);
    check("run_async_running", running, 0);
    check("run_async_sys_rst", sys_rst, 1);
    check("run_async_lost_cnt", lock_lost_cnt, 0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
